alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit clocked ALU among NREQ requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode ports. It waits out the ALU's one-cycle register latency, then returns result, carry and a locally computed zero flag, tagged with the requester ID. It sits between the client blocks and the single ALU instance.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arbiter_rr_grant.sv | 46 ++++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, default operand width and arbiter FSM encoding
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_SHL   = 3'b101;
   localparam logic [2:0] OP_SHR   = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Only add/subtract produce a meaningful carry out of the ALU.
   function automatic logic op_has_carry(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// rtl/alu_arbiter_rr_grant.sv - one-hot grant picker (rr_grant); ALU_ARB_FIXED_PRIO_EN selects fixed priority
module rr_grant #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
   input  logic [IDW-1:0]  ptr,
`endif
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = |req;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) gnt_idx = IDW'(i);
      end
      if (any) gnt[gnt_idx] = 1'b1;
   end
`else
   logic [IDW:0] cand;

   // Walk upward from ptr, wrapping modulo NREQ; first valid requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!any && req[cand[IDW-1:0]]) begin
            any     = 1'b1;
            gnt_idx = cand[IDW-1:0];
         end
      end
      if (any) gnt[gnt_idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered ALU among NREQ requesters; ALU_ARB_FIXED_PRIO_EN selects fixed priority
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = ALU_W,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*3-1:0] req_op,
   output logic [NREQ-1:0]   req_ready,
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   output logic [2:0]        alu_op,
   input  logic [W-1:0]      alu_result,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_result,
   output logic              rsp_carry,
   output logic              rsp_zero
);

   arb_state_t      state_q, state_d;
   logic [W-1:0]    alu_a_q, alu_a_d;
   logic [W-1:0]    alu_b_q, alu_b_d;
   logic [2:0]      alu_op_q, alu_op_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [W-1:0]    rsp_result_q, rsp_result_d;
   logic            rsp_carry_q, rsp_carry_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]  ptr_q, ptr_d;
`endif

   rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
      .req     (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
      .ptr     (ptr_q),
`endif
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   // Held low while reset is asserted so no requester sees a grant it cannot complete.
   assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               alu_a_d  = req_a[int'(gnt_idx)*W +: W];
               alu_b_d  = req_b[int'(gnt_idx)*W +: W];
               alu_op_d = req_op[int'(gnt_idx)*3 +: 3];
               id_d     = gnt_idx;
               state_d  = ST_ISSUE;
`ifndef ALU_ARB_FIXED_PRIO_EN
               ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`endif
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            // ALU output is valid only now; its own zero flag lags, so derive ours here.
            rsp_result_d = alu_result;
            rsp_carry_d  = op_has_carry(alu_op_q) & alu_carry;
            rsp_zero_d   = (alu_result == '0);
            rsp_valid_d  = 1'b1;
            alu_a_d      = '0;
            alu_b_d      = '0;
            alu_op_d     = '0;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         ptr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a registered ALU stand-in
`timescale 1ns/1ps
module tb_alu_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ*3-1:0] req_op;
   logic [NREQ-1:0]   req_ready;
   logic [W-1:0]      alu_a;
   logic [W-1:0]      alu_b;
   logic [2:0]        alu_op;
   logic [W-1:0]      alu_result;
   logic              alu_carry;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_result;
   logic              rsp_carry;
   logic              rsp_zero;

   int vectors     = 0;
   int miscompares = 0;
   int mptr        = 0;

   alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_ready  (req_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_zero   (rsp_zero)
   );

   always #5 clk = ~clk;

   // {carry, result} of the 4-bit ALU from plain arithmetic.
   function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         3'b000:  return {1'b0, a} + {1'b0, b};
         3'b001:  return {1'b0, a} - {1'b0, b};
         3'b010:  return {1'b0, a & b};
         3'b011:  return {1'b0, a | b};
         3'b100:  return {1'b0, a ^ b};
         3'b101:  return {a, 1'b0};
         3'b110:  return {2'b00, a[3:1]};
         default: return {1'b0, b};
      endcase
   endfunction

   // Registered ALU stand-in; carry is junk for ops without a real carry.
   logic [4:0] alu_v;
   always @(posedge clk) begin
      alu_v = alu_ref(alu_a, alu_b, alu_op);
      alu_result <= alu_v[3:0];
      alu_carry  <= (alu_op == 3'b000 || alu_op == 3'b001) ? alu_v[4] : (($urandom & 1) != 0);
   end

   function automatic int model_grant(input logic [3:0] mask, input int p);
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (mask[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // One full transaction from an IDLE negedge; returns at the negedge after the rsp handshake.
   task automatic txn(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b,
                      input logic [11:0] op, input int stall);
      int         g;
      logic [3:0] ea, eb, eres;
      logic [2:0] eo;
      logic [4:0] v;
      logic       ec;
      logic [3:0] onehot;
      req_valid = mask; req_a = a; req_b = b; req_op = op; rsp_ready = 1'b0;
      #1;
      g      = model_grant(mask, mptr);
      onehot = 4'b0001 << g;
      ea = a[g*4 +: 4]; eb = b[g*4 +: 4]; eo = op[g*3 +: 3];
      v    = alu_ref(ea, eb, eo);
      eres = v[3:0];
      ec   = (eo == 3'b000 || eo == 3'b001) ? v[4] : 1'b0;
      chk("grant", 32'(req_ready), 32'(onehot));
      @(negedge clk);
      chk("issue_a", 32'(alu_a), 32'(ea));
      chk("issue_b", 32'(alu_b), 32'(eb));
      chk("issue_op", 32'(alu_op), 32'(eo));
      chk("issue_ready", 32'(req_ready), 0);
      chk("issue_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("wait_a", 32'(alu_a), 32'(ea));
      chk("wait_op", 32'(alu_op), 32'(eo));
      chk("wait_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) rsp_ready = 1'b1;
         #1;
         chk("rsp_valid", 32'(rsp_valid), 1);
         chk("rsp_id", 32'(rsp_id), 32'(g));
         chk("rsp_result", 32'(rsp_result), 32'(eres));
         chk("rsp_carry", 32'(rsp_carry), 32'(ec));
         chk("rsp_zero", 32'(rsp_zero), (eres == 4'h0) ? 1 : 0);
         chk("resp_ready_low", 32'(req_ready), 0);
         chk("resp_alu_a", 32'(alu_a), 0);
         chk("resp_alu_op", 32'(alu_op), 0);
         @(negedge clk);
      end
      chk("rsp_drop", 32'(rsp_valid), 0);
      mptr = (g + 1) % NREQ;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_zero", 32'(rsp_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Idle with nothing requested, then a requester that drops before any edge.
      #1;
      chk("idle_ready", 32'(req_ready), 0);
      req_valid = 4'b1000;
      #1;
      req_valid = 4'b0000;
      @(negedge clk);
      chk("idle_alu_op", 32'(alu_op), 0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);

      txn(4'b0010, {4{4'h9}}, {4{4'h8}}, {4{3'b000}}, 0);
      txn(4'b0001, {4{4'h5}}, {4{4'h5}}, {4{3'b001}}, 0);
      txn(4'b1000, {4{4'hA}}, {4{4'h5}}, {4{3'b010}}, 0);

      for (int i = 0; i < 5; i++)
         txn(4'b1111, 16'($urandom), 16'($urandom), 12'($urandom), 0);

      txn(4'b1111, 16'h3C5A, 16'h1234, {4{3'b000}}, 10);

      for (int i = 0; i < 60; i++) begin
         if (($urandom % 5) == 0) begin
            req_valid = '0;
            #1;
            chk("rand_idle_ready", 32'(req_ready), 0);
            @(negedge clk);
         end
         txn(4'($urandom_range(15, 1)), 16'($urandom), 16'($urandom), 12'($urandom),
             int'($urandom_range(3, 0)));
      end

      // Reset during WAIT aborts the transaction without a response.
      req_valid = 4'b0100; req_a = {4{4'h7}}; req_b = {4{4'h6}}; req_op = {4{3'b000}};
      #1;
      chk("pre_rst_grant", 32'(req_ready), 32'(4'b0001 << model_grant(4'b0100, mptr)));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 0);
      chk("midrst_alu_a", 32'(alu_a), 0);
      chk("midrst_alu_b", 32'(alu_b), 0);
      chk("midrst_alu_op", 32'(alu_op), 0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 0);
      chk("midrst_rsp_id", 32'(rsp_id), 0);
      chk("midrst_rsp_result", 32'(rsp_result), 0);
      chk("midrst_rsp_carry", 32'(rsp_carry), 0);
      chk("midrst_rsp_zero", 32'(rsp_zero), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_hold_valid", 32'(rsp_valid), 0);
      end
      rst_n = 1'b1;
      mptr  = 0;
      txn(4'b1100, {4{4'h3}}, {4{4'h4}}, {4{3'b011}}, 1);
      txn(4'b0100, {4{4'hF}}, {4{4'h1}}, {4{3'b000}}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
